stopwatch_ctrl: RTL

//  Sequencer for a mm:ss stopwatch built from two cascaded 00-59 BCD counters
//  (seconds, minutes). Generates the 1 Hz seconds enable from clk, forwards the

---
 rtl/stopwatch_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - mm:ss stopwatch sequencer: 1 Hz prescaler, run/pause/clear/lap FSM, overflow flag
module stopwatch_ctrl #(
    parameter int DIV      = 50_000_000,
    parameter int DIV_W    = 26,
    parameter bit OVF_STOP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    input  logic       sec_tick,
    input  logic       min_tick,
    output logic       sec_en,
    output logic       min_en,
    output logic       cnt_clr,
    output logic       running,
    output logic       hold,
    output logic       ovf,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        OVF   = 2'b11
    } state_t;

    state_t             cur;
    state_t             nxt;
    logic               lap_ok;
    logic               adv;
    logic               wrap;
    logic [DIV_W-1:0]   presc;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Next state with priority clear > min_tick > start_stop > lap
    always_comb begin
        nxt    = cur;
        lap_ok = 1'b0;
        if (clear) begin
            nxt = IDLE;
        end else begin
            case (cur)
                IDLE: begin
                    if (start_stop) nxt = RUN;
                end
                RUN: begin
                    if (min_tick && OVF_STOP) nxt = OVF;
                    else if (start_stop)      nxt = PAUSE;
                    else                      lap_ok = lap;
                end
                PAUSE: begin
                    if (start_stop) nxt = RUN;
                    else            lap_ok = lap;
                end
                default: nxt = cur;
            endcase
        end
    end

    // Prescaler only advances on cycles that stay in RUN, so leaving RUN freezes its phase
    assign adv  = (cur == RUN) && (nxt == RUN);
    assign wrap = (presc == DIV_W'(DIV - 1));

    // Prescaler, seconds enable, clear pulse and lap hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc   <= '0;
            sec_en  <= 1'b0;
            cnt_clr <= 1'b0;
            hold    <= 1'b0;
        end else begin
            cnt_clr <= clear;
            sec_en  <= adv && wrap;
            if (clear) begin
                presc <= '0;
            end else if (adv) begin
                presc <= wrap ? '0 : presc + 1'b1;
            end
            if (clear) begin
                hold <= 1'b0;
            end else if (lap_ok) begin
                hold <= ~hold;
            end
        end
    end

    assign min_en  = sec_tick & (cur != IDLE);
    assign running = (cur == RUN);
    assign ovf     = (cur == OVF);
    assign state   = cur;

endmodule
